// File: rtl/ecc_kscan_pkg.sv
// Shared encodings for the ECC scalar-digit scanner.
// One-hot state, digit-select codes and load-mode constants.
package ecc_kscan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_SKIP = 3'b010,
    ST_SCAN = 3'b100
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_P    = 2'b01;
  localparam logic [1:0] SEL_Q    = 2'b10;
  localparam logic [1:0] SEL_PQ   = 2'b11;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_JOINT  = 1'b1;

endpackage

// File: rtl/ecc_kscan.sv
// Scalar-digit scanner: loads k (or u1/u2), skips leading zeros, then streams
// one MSB-first {k1,k0} digit per bit to the point add/double sequencer.
module ecc_kscan
  import ecc_kscan_pkg::*;
#(
  parameter int KW = 256,
  parameter int CW = $clog2(KW + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_k_clr,
  input  logic          i_ld_valid,
  output logic          o_ld_ready,
  input  logic          i_ld_mode,
  input  logic [KW-1:0] i_ld_k0,
  input  logic [KW-1:0] i_ld_k1,
  output logic          o_dig_valid,
  input  logic          i_dig_ready,
  output logic          o_dig_dbl,
  output logic [1:0]    o_dig_sel,
  output logic          o_dig_last,
  output logic          o_k_zero,
  output logic          o_busy,
  output logic [CW-1:0] o_pos
);

  localparam logic [CW-1:0] POS_LAST = CW'(KW - 1);

  state_t        r_state;
  logic [KW-1:0] r_k0;
  logic [KW-1:0] r_k1;
  logic [CW-1:0] r_pos;
  logic          r_first;
  logic          r_k_zero;

  state_t        w_state_nxt;
  logic [KW-1:0] w_k0_nxt;
  logic [KW-1:0] w_k1_nxt;
  logic [CW-1:0] w_pos_nxt;
  logic          w_first_nxt;
  logic          w_k_zero_nxt;

  logic [KW-1:0] w_eff_k1;
  logic          w_eff_zero;
  logic          w_msb;
  logic          w_last;

  // Single mode forces the Q scalar to zero so it never selects Q.
  assign w_eff_k1   = (i_ld_mode == MODE_JOINT) ? i_ld_k1 : '0;
  assign w_eff_zero = (i_ld_k0 == '0) && (w_eff_k1 == '0);
  assign w_msb      = r_k0[KW-1] | r_k1[KW-1];
  assign w_last     = (r_pos == POS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_k0     <= '0;
      r_k1     <= '0;
      r_pos    <= '0;
      r_first  <= 1'b0;
      r_k_zero <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_k0     <= w_k0_nxt;
      r_k1     <= w_k1_nxt;
      r_pos    <= w_pos_nxt;
      r_first  <= w_first_nxt;
      r_k_zero <= w_k_zero_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_k0_nxt     = r_k0;
    w_k1_nxt     = r_k1;
    w_pos_nxt    = r_pos;
    w_first_nxt  = r_first;
    w_k_zero_nxt = r_k_zero;
    if (i_k_clr) begin
      w_state_nxt  = ST_IDLE;
      w_k0_nxt     = '0;
      w_k1_nxt     = '0;
      w_pos_nxt    = '0;
      w_first_nxt  = 1'b0;
      w_k_zero_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_ld_valid) begin
            w_k0_nxt     = i_ld_k0;
            w_k1_nxt     = w_eff_k1;
            w_pos_nxt    = '0;
            w_first_nxt  = 1'b1;
            w_k_zero_nxt = w_eff_zero;
            w_state_nxt  = w_eff_zero ? ST_IDLE : ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (w_msb) begin
            w_state_nxt = ST_SCAN;
          end else begin
            w_k0_nxt  = {r_k0[KW-2:0], 1'b0};
            w_k1_nxt  = {r_k1[KW-2:0], 1'b0};
            w_pos_nxt = r_pos + 1'b1;
          end
        end
        ST_SCAN: begin
          if (i_dig_ready) begin
            w_k0_nxt    = {r_k0[KW-2:0], 1'b0};
            w_k1_nxt    = {r_k1[KW-2:0], 1'b0};
            w_pos_nxt   = r_pos + 1'b1;
            w_first_nxt = 1'b0;
            if (w_last) w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Digit outputs come straight from registers so they hold under backpressure.
  assign o_ld_ready  = (r_state == ST_IDLE);
  assign o_dig_valid = (r_state == ST_SCAN);
  assign o_dig_sel   = o_dig_valid ? {r_k1[KW-1], r_k0[KW-1]} : SEL_NONE;
  assign o_dig_dbl   = o_dig_valid & ~r_first;
  assign o_dig_last  = o_dig_valid & w_last;
  assign o_k_zero    = r_k_zero;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_pos       = r_pos;

endmodule

// File: tb/tb_ecc_kscan.sv
// Directed bench for ecc_kscan: an 8-bit instance for sequencing scenarios
// and a 256-bit instance for the full-width boundary cases.
module tb_ecc_kscan;

  logic clk;
  logic rst_n;

  logic         a_k_clr, a_ld_valid, a_ld_ready, a_ld_mode;
  logic [7:0]   a_ld_k0, a_ld_k1;
  logic         a_dig_valid, a_dig_ready, a_dig_dbl, a_dig_last;
  logic [1:0]   a_dig_sel;
  logic         a_k_zero, a_busy;
  logic [3:0]   a_pos;

  logic         b_k_clr, b_ld_valid, b_ld_ready, b_ld_mode;
  logic [255:0] b_ld_k0, b_ld_k1;
  logic         b_dig_valid, b_dig_ready, b_dig_dbl, b_dig_last;
  logic [1:0]   b_dig_sel;
  logic         b_k_zero, b_busy;
  logic [8:0]   b_pos;

  int n_tests;
  int n_fail;
  int cyc;

  ecc_kscan #(.KW(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_k_clr(a_k_clr),
    .i_ld_valid(a_ld_valid), .o_ld_ready(a_ld_ready), .i_ld_mode(a_ld_mode),
    .i_ld_k0(a_ld_k0), .i_ld_k1(a_ld_k1),
    .o_dig_valid(a_dig_valid), .i_dig_ready(a_dig_ready), .o_dig_dbl(a_dig_dbl),
    .o_dig_sel(a_dig_sel), .o_dig_last(a_dig_last),
    .o_k_zero(a_k_zero), .o_busy(a_busy), .o_pos(a_pos)
  );

  ecc_kscan #(.KW(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .i_k_clr(b_k_clr),
    .i_ld_valid(b_ld_valid), .o_ld_ready(b_ld_ready), .i_ld_mode(b_ld_mode),
    .i_ld_k0(b_ld_k0), .i_ld_k1(b_ld_k1),
    .o_dig_valid(b_dig_valid), .i_dig_ready(b_dig_ready), .o_dig_dbl(b_dig_dbl),
    .o_dig_sel(b_dig_sel), .o_dig_last(b_dig_last),
    .o_k_zero(b_k_zero), .o_busy(b_busy), .o_pos(b_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle8(input string tag, input logic [3:0] exp_pos, input logic exp_kz);
    check({tag, "_ld_ready"}, a_ld_ready, 1'b1);
    check({tag, "_valid"},    a_dig_valid, 1'b0);
    check({tag, "_dbl"},      a_dig_dbl, 1'b0);
    check({tag, "_sel"},      a_dig_sel, 2'b00);
    check({tag, "_last"},     a_dig_last, 1'b0);
    check({tag, "_busy"},     a_busy, 1'b0);
    check({tag, "_pos"},      a_pos, exp_pos);
    check({tag, "_kzero"},    a_k_zero, exp_kz);
  endtask

  task automatic load8(input logic mode, input logic [7:0] k0, input logic [7:0] k1);
    a_ld_mode  = mode;
    a_ld_k0    = k0;
    a_ld_k1    = k1;
    a_ld_valid = 1'b1;
    step();
    a_ld_valid = 1'b0;
  endtask

  task automatic wait_valid8(input string tag, input int exp_cyc);
    int c;
    c = 0;
    while (!a_dig_valid && c < 400) begin
      step();
      c++;
    end
    check({tag, "_skip_cycles"}, c, exp_cyc);
  endtask

  // Checks the presented digit, then lets one edge pass (consumed if ready).
  task automatic dig8(input string tag, input logic dbl, input logic [1:0] sel, input logic last);
    check({tag, "_valid"}, a_dig_valid, 1'b1);
    check({tag, "_dbl"},   a_dig_dbl, dbl);
    check({tag, "_sel"},   a_dig_sel, sel);
    check({tag, "_last"},  a_dig_last, last);
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    a_k_clr = 1'b0; a_ld_valid = 1'b0; a_ld_mode = 1'b0;
    a_ld_k0 = '0; a_ld_k1 = '0; a_dig_ready = 1'b1;
    b_k_clr = 1'b0; b_ld_valid = 1'b0; b_ld_mode = 1'b0;
    b_ld_k0 = '0; b_ld_k1 = '0; b_dig_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    check_idle8("reset", 4'd0, 1'b0);
    check("reset256_busy", b_busy, 1'b0);
    check("reset256_ready", b_ld_ready, 1'b1);

    // Scenario 1: single 0x05, lz=5
    load8(1'b0, 8'h05, 8'hFF);
    check("s1_busy", a_busy, 1'b1);
    check("s1_ld_ready", a_ld_ready, 1'b0);
    check("s1_pos0", a_pos, 4'd0);
    wait_valid8("s1", 6);
    check("s1_pos_scan", a_pos, 4'd5);
    dig8("s1_d0", 1'b0, 2'b01, 1'b0);
    dig8("s1_d1", 1'b1, 2'b00, 1'b0);
    dig8("s1_d2", 1'b1, 2'b01, 1'b1);
    check_idle8("s1_end", 4'd8, 1'b0);

    // Scenario 2: joint k0=0x0B k1=0x06; a load attempt during SKIP is ignored
    load8(1'b1, 8'h0B, 8'h06);
    a_ld_valid = 1'b1; a_ld_k0 = 8'hFF; a_ld_k1 = 8'hFF;
    step();
    a_ld_valid = 1'b0;
    wait_valid8("s2", 4);
    check("s2_pos_scan", a_pos, 4'd4);
    dig8("s2_d0", 1'b0, 2'b01, 1'b0);
    dig8("s2_d1", 1'b1, 2'b10, 1'b0);
    dig8("s2_d2", 1'b1, 2'b11, 1'b0);
    dig8("s2_d3", 1'b1, 2'b01, 1'b1);
    check_idle8("s2_end", 4'd8, 1'b0);

    // Scenario 3: zero scalar in single mode (k1 ignored)
    load8(1'b0, 8'h00, 8'hFF);
    check_idle8("s3_zero", 4'd0, 1'b1);
    step();
    step();
    check_idle8("s3_hold", 4'd0, 1'b1);
    load8(1'b0, 8'h80, 8'h00);
    check("s3_kzero_clr", a_k_zero, 1'b0);
    check("s3_busy", a_busy, 1'b1);
    wait_valid8("s3", 1);
    dig8("s3_d0", 1'b0, 2'b01, 1'b0);
    for (int i = 1; i < 7; i++) dig8("s3_dmid", 1'b1, 2'b00, 1'b0);
    dig8("s3_d7", 1'b1, 2'b00, 1'b1);
    check_idle8("s3_end", 4'd8, 1'b0);

    // Scenario 5: backpressure on scenario 2
    load8(1'b1, 8'h0B, 8'h06);
    wait_valid8("s5", 5);
    dig8("s5_d0", 1'b0, 2'b01, 1'b0);
    a_dig_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("s5_hold_valid", a_dig_valid, 1'b1);
      check("s5_hold_dbl", a_dig_dbl, 1'b1);
      check("s5_hold_sel", a_dig_sel, 2'b10);
      check("s5_hold_last", a_dig_last, 1'b0);
      check("s5_hold_pos", a_pos, 4'd5);
    end
    a_dig_ready = 1'b1;
    dig8("s5_d1", 1'b1, 2'b10, 1'b0);
    dig8("s5_d2", 1'b1, 2'b11, 1'b0);
    dig8("s5_d3", 1'b1, 2'b01, 1'b1);
    check_idle8("s5_end", 4'd8, 1'b0);

    // Scenario 6a: k_clr mid-scan, then k_clr beats a simultaneous load
    load8(1'b0, 8'h05, 8'h00);
    wait_valid8("s6a", 6);
    dig8("s6a_d0", 1'b0, 2'b01, 1'b0);
    a_k_clr = 1'b1;
    step();
    a_k_clr = 1'b0;
    check_idle8("s6a_clr", 4'd0, 1'b0);
    step();
    step();
    check_idle8("s6a_quiet", 4'd0, 1'b0);
    a_k_clr = 1'b1;
    load8(1'b0, 8'h05, 8'h00);
    a_k_clr = 1'b0;
    check_idle8("s6a_clr_vs_load", 4'd0, 1'b0);
    load8(1'b0, 8'h00, 8'h00);
    check("s6a_kz_set", a_k_zero, 1'b1);
    a_k_clr = 1'b1;
    step();
    a_k_clr = 1'b0;
    check("s6a_kz_clr", a_k_zero, 1'b0);

    // Scenario 6b: reset pulse during SKIP, then a clean rerun
    load8(1'b0, 8'h05, 8'h00);
    step();
    check("s6b_in_skip", a_busy, 1'b1);
    rst_n = 1'b0;
    step();
    check_idle8("s6b_rst", 4'd0, 1'b0);
    rst_n = 1'b1;
    step();
    check_idle8("s6b_after", 4'd0, 1'b0);
    load8(1'b0, 8'h05, 8'h00);
    wait_valid8("s6b", 6);
    dig8("s6b_d0", 1'b0, 2'b01, 1'b0);
    dig8("s6b_d1", 1'b1, 2'b00, 1'b0);
    dig8("s6b_d2", 1'b1, 2'b01, 1'b1);
    check_idle8("s6b_end", 4'd8, 1'b0);

    // Scenario 4: KW=256 boundaries
    b_ld_mode = 1'b0;
    b_ld_k0 = 256'd1;
    b_ld_valid = 1'b1;
    step();
    b_ld_valid = 1'b0;
    cyc = 0;
    while (!b_dig_valid && cyc < 1000) begin
      step();
      cyc++;
    end
    check("s4a_skip_cycles", cyc, 256);
    check("s4a_pos", b_pos, 9'd255);
    check("s4a_dbl", b_dig_dbl, 1'b0);
    check("s4a_sel", b_dig_sel, 2'b01);
    check("s4a_last", b_dig_last, 1'b1);
    step();
    check("s4a_busy_end", b_busy, 1'b0);
    check("s4a_pos_end", b_pos, 9'd256);

    b_ld_k0 = 256'd1 << 255;
    b_ld_valid = 1'b1;
    step();
    b_ld_valid = 1'b0;
    cyc = 0;
    while (!b_dig_valid && cyc < 1000) begin
      step();
      cyc++;
    end
    check("s4b_skip_cycles", cyc, 1);
    check("s4b_d0_dbl", b_dig_dbl, 1'b0);
    check("s4b_d0_sel", b_dig_sel, 2'b01);
    check("s4b_d0_last", b_dig_last, 1'b0);
    step();
    for (int i = 1; i < 256; i++) begin
      check("s4b_valid", b_dig_valid, 1'b1);
      check("s4b_dbl", b_dig_dbl, 1'b1);
      check("s4b_sel", b_dig_sel, 2'b00);
      check("s4b_last", b_dig_last, (i == 255) ? 1'b1 : 1'b0);
      step();
    end
    check("s4b_busy_end", b_busy, 1'b0);
    check("s4b_pos_end", b_pos, 9'd256);
    check("s4b_ready_end", b_ld_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
